// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the multiply/divide execution unit.
// Op encodings follow funct3 so the captured field can be cast directly.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

    localparam int MULDIV_ITERS   = 32;
    localparam int MULDIV_LATENCY = 35;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 35-cycle latency.
// One 64-bit shift register serves as product accumulator or remainder:quotient.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    muldiv_state_e state, state_next;
    muldiv_op_e    op_q;

    logic [XLEN-1:0]   a_q, b_q, mag_b_q;
    logic [4:0]        rd_q;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] acc;

    logic              a_sgn, b_sgn, is_div, div_by_zero, sgn_ovf;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_partial, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fixed;
    logic [XLEN-1:0]   quot_fixed, rem_fixed, fix_result;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = CALC;
            CALC:    if (cnt == 5'(MULDIV_ITERS - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand signedness depends on the op; captured operands stay stable until FIX.
    always_comb begin
        is_div      = op_q[2];
        a_sgn       = a_q[XLEN-1] & ((op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                                     (op_q == OP_DIV)  || (op_q == OP_REM));
        b_sgn       = b_q[XLEN-1] & ((op_q == OP_MULH) || (op_q == OP_DIV) ||
                                     (op_q == OP_REM));
        mag_a       = a_sgn ? -a_q : a_q;
        mag_b       = b_sgn ? -b_q : b_q;
        div_by_zero = (b_q == '0);
        sgn_ovf     = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    end

    always_comb begin
        mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_q} : '0);
        mul_next    = {mul_sum, acc[XLEN-1:1]};
        div_partial = acc[2*XLEN-1:XLEN-1];
        div_diff    = div_partial - {1'b0, mag_b_q};
        if (div_diff[XLEN])
            div_next = {div_partial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // Sign correction and special-case overrides applied on the final shift-register value.
    always_comb begin
        prod_fixed = (a_sgn ^ b_sgn) ? -acc : acc;
        quot_fixed = ((a_sgn ^ b_sgn) && !div_by_zero) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fixed  = a_sgn ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op_q)
            OP_MUL:    fix_result = prod_fixed[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  fix_result = prod_fixed[2*XLEN-1:XLEN];
            OP_DIV:    fix_result = div_by_zero ? '1 : (sgn_ovf ? 32'h8000_0000 : quot_fixed);
            OP_DIVU:   fix_result = div_by_zero ? '1 : quot_fixed;
            OP_REM:    fix_result = div_by_zero ? a_q : (sgn_ovf ? '0 : rem_fixed);
            OP_REMU:   fix_result = div_by_zero ? a_q : rem_fixed;
            default:   fix_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            mag_b_q <= '0;
            rd_q    <= '0;
            cnt     <= '0;
            acc     <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= muldiv_op_e'(funct3);
                    a_q  <= a;
                    b_q  <= b;
                    rd_q <= rd_in;
                end
                PREP: begin
                    mag_b_q <= mag_b;
                    acc     <= {{XLEN{1'b0}}, mag_a};
                    cnt     <= '0;
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    acc <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    result <= fix_result;
                    rd_out <= rd_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, special cases,
// ignored starts, mid-op reset and randomised ops against a behavioural model.
module tb_muldiv_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [36:0] sb_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    // Behavioural RV32M reference built on the simulator's own arithmetic.
    function automatic logic [31:0] refModel(logic [2:0] f, logic [31:0] x, logic [31:0] y);
        logic [63:0] xe, ye, p;
        logic [31:0] r;
        int          sx, sy;
        xe = (f == 3'b001 || f == 3'b010) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (f == 3'b001) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        sx = x;
        sy = y;
        r  = '0;
        case (f)
            3'b000: r = p[31:0];
            3'b001,
            3'b010,
            3'b011: r = p[63:32];
            3'b100: if (y == 0) r = 32'hFFFF_FFFF;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
                    else r = 32'(sx / sy);
            3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: if (y == 0) r = x;
                    else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
                    else r = 32'(sx % sy);
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    task automatic checkValue(string tag, logic [36:0] obs, logic [36:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives start for exactly one rising edge (cycle 0); the unit must be idle beforehand.
    task automatic applyStimulus(logic [2:0] f, logic [31:0] x, logic [31:0] y,
                                 logic [4:0] r, logic [31:0] exp, bit push);
        @(negedge clk);
        checkValue("idle_busy_before_start", 37'(busy), 37'(1'b0));
        checkValue("idle_done_before_start", 37'(done), 37'(1'b0));
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        rd_in  = r;
        if (push) sb_q.push_back({r, exp});
    endtask

    // Tracks cycles 1..40 after start; optionally injects new starts in cycles inj1/inj2.
    task automatic checkOutput(string tag, int inj1, int inj2);
        bit          seen = 1'b0;
        int          done_cycle = -1;
        logic [36:0] exp;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            checkValue({tag, "_busy"}, 37'(busy), 37'(1'b1));
            if (done) begin
                seen       = 1'b1;
                done_cycle = k;
            end
            if (k == inj1 || k == inj2) begin
                start  = 1'b1;
                funct3 = 3'($urandom);
                rd_in  = 5'($urandom);
            end else begin
                start  = 1'b0;
            end
            a = $urandom;
            b = $urandom;
        end
        checkValue({tag, "_done_cycle"}, 37'(done_cycle), 37'(MULDIV_LATENCY));
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 37'h0;
        checkValue({tag, "_rd_result"}, {rd_out, result}, exp);
    endtask

    initial begin
        int done_seen;
        logic [2:0]  f;
        logic [31:0] x, y;
        logic [4:0]  r;

        reset  = 1'b1;
        start  = 1'b1;
        funct3 = 3'b100;
        a      = 32'd9;
        b      = 32'd3;
        rd_in  = 5'd7;
        repeat (3) @(negedge clk);
        checkValue("reset_busy", 37'(busy), 37'(1'b0));
        checkValue("reset_done", 37'(done), 37'(1'b0));
        checkValue("reset_result", 37'(result), 37'h0);
        checkValue("reset_rd_out", 37'(rd_out), 37'h0);
        start = 1'b0;
        reset = 1'b0;

        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);
        checkOutput("mul_neg", -1, -1);
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1'b1);
        checkOutput("mulhu", -1, -1);
        applyStimulus(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 1'b1);
        checkOutput("mulh", -1, -1);
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 1'b1);
        checkOutput("mulhsu", -1, -1);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b1);
        checkOutput("div_neg", -1, -1);
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b1);
        checkOutput("rem_neg", -1, -1);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 1'b1);
        checkOutput("divu", -1, -1);
        applyStimulus(OP_REMU, 32'd100, 32'd7, 5'd0, 32'd2, 1'b1);
        checkOutput("remu_x0", -1, -1);
        applyStimulus(OP_DIV, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1'b1);
        checkOutput("div_by_zero", -1, -1);
        applyStimulus(OP_REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1'b1);
        checkOutput("remu_by_zero", -1, -1);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b1);
        checkOutput("div_overflow", -1, -1);
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0, 1'b1);
        checkOutput("rem_overflow", -1, -1);

        // Starts in cycles 5 and 35 must be ignored; the one in cycle 36 is accepted.
        applyStimulus(OP_MUL, 32'd1000, 32'd1000, 5'd16, 32'd1_000_000, 1'b1);
        checkOutput("ignored_starts", 5, 35);
        applyStimulus(OP_DIVU, 32'd1000, 32'd10, 5'd17, 32'd100, 1'b1);
        checkOutput("start_cycle36", -1, -1);

        // Reset in cycle 10 of a DIV aborts it with no done.
        applyStimulus(OP_DIV, 32'd1234, 32'd5, 5'd18, 32'd0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        checkValue("abort_busy", 37'(busy), 37'(1'b0));
        checkValue("abort_done", 37'(done), 37'(1'b0));
        checkValue("abort_result", 37'(result), 37'h0);
        checkValue("abort_rd_out", 37'(rd_out), 37'h0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkValue("abort_no_done", 37'(done_seen), 37'h0);
        applyStimulus(OP_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 1'b1);
        checkOutput("mul_after_abort", -1, -1);

        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom);
            x = (i % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            y = (i % 5 == 0) ? 32'h0 : ((i % 3 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
            r = 5'($urandom);
            applyStimulus(f, x, y, r, refModel(f, x, y), 1'b1);
            checkOutput("random_op", -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit. Consumes the two source-operand values read from the register file, runs a fixed-latency shift-add multiply or restoring divide, and presents a 32-bit result plus destination register index for the register file's synchronous write port. The integrating datapath drives the register-file write enable from `done`, the write address from `rd_out` and the write data from `result`.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  32  rs1 value (rd1).
- `b`  in  32  rs2 value (rd2).
- `rd_in`  in  5  destination register index.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `result`  out  32  registered result.
- `rd_out`  out  5  registered destination index.

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: if `start`, capture `a`, `b`, `funct3`, `rd_in` and go to PREP. Inputs are not sampled again until the next accepted start.
- PREP (1 cycle):
  - Compute operand signs per op: MULH both signed; MULHSU `a` signed, `b` unsigned; DIV/REM both signed; all others unsigned.
  - Take magnitudes and clear the 5-bit iteration counter.
- CALC (exactly 32 cycles, counter 0..31):
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring, 33-bit partial-remainder subtract, one quotient bit per cycle, MSB first.
- FIX (1 cycle):
  - Apply sign correction to the 64-bit product, quotient or remainder.
  - Select the output: low word for MUL, high word for MULH/MULHSU/MULHU.
  - Load `result` and `rd_out`, then go to DONE.
- DONE (1 cycle): `done`=1, then return to IDLE.
- Sign rules:
  - Quotient is negative iff the operand signs differ and the divisor is nonzero.
  - Remainder takes the sign of the dividend.
- Special cases are overridden in FIX; latency is unchanged.
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend unchanged.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- `rd_out`=0 is passed through unchanged; the register file discards writes to x0.
- `result`/`rd_out` hold their value from DONE until the next FIX.

## Timing
- Call the cycle in which `start` is high in IDLE cycle 0.
  - Cycle 1: PREP.
  - Cycles 2–33: CALC.
  - Cycle 34: FIX.
  - Cycle 35: DONE.
- `busy` is high in cycles 1–35; `done` is high in cycle 35 only.
- Latency is fixed at 35 cycles for all eight ops and all operand values.
- `start` while `busy`=1 is ignored, including during DONE. The earliest next accepted start is cycle 36.
- Operand changes after cycle 0 have no effect.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0; internal operand, product, quotient and counter registers also 0.
- Reset dominates `start` in the same cycle.
- Reset mid-operation (any state) aborts: at the next edge all outputs return to reset values and no `done` is produced for the aborted op.

## Structure
- Shared package `riscv_pkg` holds:
  - `muldiv_op_e` enum on the `funct3` encodings.
  - `muldiv_state_e` (IDLE, PREP, CALC, FIX, DONE).
  - Constants `MULDIV_ITERS`=32 and `MULDIV_LATENCY`=35.
- Single module: FSM, counter and shared shift datapath in one file, with no sub-module. Multiply and divide reuse the same 64-bit shift register (product accumulator, or remainder:quotient).

## Test plan
- MUL a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB, `rd_out`=`rd_in`, `done` exactly in cycle 35, `busy` high cycles 1–35.
- a=b=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- Division:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - All with latency 35.
- `start` pulsed with new operands in cycles 5 and 35 of a running op → both ignored, result unaffected. A start in cycle 36 is accepted.
- `reset` in cycle 10 of a DIV → cycle 11 `busy`=0, `result`=0, no `done`. A following MUL 3×4 yields 12 at 35 cycles.
